aes_shift_rows_stage: RTL

- Registered ShiftRows / InvShiftRows stage placed directly downstream of SubBytes in the AES round datapath.
- Takes a SIZE-bit word holding SIZE/128 AES states.
- Applies the row permutation to every state and buffers results in a small FIFO.
- Uses a valid/ready handshake on both sides, so the round pipeline can stall without losing data.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_shift_rows_comb.sv | 30 +++
 rtl/aes_shift_rows_stage.sv | 86 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_pkg : AES state geometry and row-slicing helper shared by round stages
// Rev 1.0
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_BITS = 128;
  localparam int AES_ROW_BITS   = 32;
  localparam int AES_NROWS      = 4;

  // Row r of one state; row 0 sits at the MSB end, byte 0 of a row is its MSB.
  function automatic logic [AES_ROW_BITS-1:0] aes_row(
    input logic [AES_BLOCK_BITS-1:0] state,
    input int unsigned               r
  );
    return state[AES_BLOCK_BITS-1-AES_ROW_BITS*r -: AES_ROW_BITS];
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_shift_rows_comb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_shift_rows_comb : combinational ShiftRows / InvShiftRows of one state
// Rev 1.0
// ---------------------------------------------------------------------------
module aes_shift_rows_comb
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_BITS-1:0] state,
  input  logic                      inv,
  output logic [AES_BLOCK_BITS-1:0] permuted
);

  for (genvar r = 0; r < AES_NROWS; r++) begin : g_row
    logic [AES_ROW_BITS-1:0]   row;
    logic [2*AES_ROW_BITS-1:0] row_dbl;
    logic [AES_ROW_BITS-1:0]   row_fwd;
    logic [AES_ROW_BITS-1:0]   row_inv;

    assign row     = aes_row(state, r);
    assign row_dbl = {row, row};
    // Rotations are plain windows into the doubled row.
    assign row_fwd = row_dbl[2*AES_ROW_BITS-1-8*r -: AES_ROW_BITS];
    assign row_inv = row_dbl[AES_ROW_BITS-1+8*r -: AES_ROW_BITS];

    assign permuted[AES_BLOCK_BITS-1-AES_ROW_BITS*r -: AES_ROW_BITS] = inv ? row_inv : row_fwd;
  end

endmodule : aes_shift_rows_comb
`default_nettype wire

// File: rtl/aes_shift_rows_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_shift_rows_stage : registered (Inv)ShiftRows over SIZE/128 states, FIFO buffered
// Rev 1.0
// ---------------------------------------------------------------------------
module aes_shift_rows_stage
  import aes_pkg::*;
#(
  parameter int SIZE  = 256,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE-1:0]            in_data,
  input  logic                       in_inv,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int NBLK  = SIZE / AES_BLOCK_BITS;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  if ((SIZE % AES_BLOCK_BITS) != 0 || SIZE <= 0) begin : g_bad_size
    $error("SIZE must be a positive multiple of 128");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("DEPTH must be at least 1");
  end

  logic [SIZE-1:0]  permuted;
  logic [SIZE-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push;
  logic             pop;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    aes_shift_rows_comb u_shift (
      .state    (in_data [SIZE-1-AES_BLOCK_BITS*k -: AES_BLOCK_BITS]),
      .inv      (in_inv),
      .permuted (permuted[SIZE-1-AES_BLOCK_BITS*k -: AES_BLOCK_BITS])
    );
  end

  // in_ready deliberately ignores out_ready: a full FIFO never accepts a word.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= permuted;
        wptr      <= next_ptr(wptr);
      end
      if (pop) begin
        rptr <= next_ptr(rptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule : aes_shift_rows_stage
`default_nettype wire
